// File: rtl/pac_gen_if.sv
// Control and word-stream bundle for pac_gen: register-side controls in,
// framed 32-bit words with sof/eof strobes and run status out.
interface pac_gen_if;
    logic        i_enable;
    logic [31:0] i_frame_cnt_max;
    logic        i_ready;
    logic        i_err_inject;
    logic [31:0] o_pac_gen_data;
    logic        o_pac_gen_data_valid;
    logic        o_pac_gen_sof;
    logic        o_pac_gen_eof;
    logic [31:0] o_frame_num;
    logic        o_busy;
    logic        o_done;

    modport master (
        input  i_enable, i_frame_cnt_max, i_ready, i_err_inject,
        output o_pac_gen_data, o_pac_gen_data_valid, o_pac_gen_sof, o_pac_gen_eof,
        output o_frame_num, o_busy, o_done
    );

    modport slave (
        output i_enable, i_frame_cnt_max, i_ready, i_err_inject,
        input  o_pac_gen_data, o_pac_gen_data_valid, o_pac_gen_sof, o_pac_gen_eof,
        input  o_frame_num, o_busy, o_done
    );
endinterface

// File: rtl/pac_gen.sv
// Test-pattern frame generator: frames of words 0..FRAME_LEN_VAL-1 separated by GAP_LEN idle cycles.
// Optional single-word bit-0 corruption is built only when PAC_GEN_ERR_INJECT_EN is defined.
module pac_gen #(
    parameter int FRAME_LEN_VAL = 40,
    parameter int GAP_LEN       = 8
) (
    input  logic      i_pac_gen_clk,
    input  logic      i_rst,
    pac_gen_if.master bus
);
    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_DATA = 2'd1,
        P_GAP  = 2'd2,
        P_DONE = 2'd3
    } state_t;

    localparam logic [31:0] LAST_IDX = 32'(FRAME_LEN_VAL - 1);
    localparam logic [31:0] GAP_END  = (GAP_LEN > 0) ? 32'(GAP_LEN - 1) : 32'd0;

    state_t      state, state_n;
    logic [31:0] idx, idx_n;
    logic [31:0] gap_cnt, gap_cnt_n;
    logic [31:0] run_cnt, run_cnt_n;
    logic [31:0] cnt_max, cnt_max_n;
    logic [31:0] frame_num, frame_num_n;
    logic        valid, valid_n;
    logic        load;
    logic        xfer;
    logic        flip_n;
    logic [31:0] data_q;
    logic        sof_q, eof_q, busy_q, done_q;

    assign xfer = valid && bus.i_ready;

    // load marks a cycle where a new word is placed on the output registers
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        gap_cnt_n   = gap_cnt;
        run_cnt_n   = run_cnt;
        cnt_max_n   = cnt_max;
        frame_num_n = frame_num;
        valid_n     = valid;
        load        = 1'b0;
        case (state)
            P_IDLE: begin
                if (bus.i_enable) begin
                    state_n   = P_DATA;
                    cnt_max_n = bus.i_frame_cnt_max;
                    run_cnt_n = 32'd0;
                    idx_n     = 32'd0;
                    valid_n   = 1'b1;
                    load      = 1'b1;
                end
            end
            P_DATA: begin
                if (xfer) begin
                    if (idx == LAST_IDX) begin
                        frame_num_n = frame_num + 32'd1;
                        run_cnt_n   = run_cnt + 32'd1;
                        valid_n     = 1'b0;
                        if (cnt_max != 32'd0 && run_cnt_n == cnt_max) begin
                            state_n = P_DONE;
                        end else if (!bus.i_enable) begin
                            state_n = P_IDLE;
                        end else if (GAP_LEN == 0) begin
                            idx_n   = 32'd0;
                            valid_n = 1'b1;
                            load    = 1'b1;
                        end else begin
                            state_n   = P_GAP;
                            gap_cnt_n = 32'd0;
                        end
                    end else begin
                        idx_n = idx + 32'd1;
                        load  = 1'b1;
                    end
                end
            end
            P_GAP: begin
                if (gap_cnt == GAP_END) begin
                    if (bus.i_enable) begin
                        state_n = P_DATA;
                        idx_n   = 32'd0;
                        valid_n = 1'b1;
                        load    = 1'b1;
                    end else begin
                        state_n = P_IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + 32'd1;
                end
            end
            P_DONE: begin
                if (!bus.i_enable) state_n = P_IDLE;
            end
            default: state_n = P_IDLE;
        endcase
    end

`ifdef PAC_GEN_ERR_INJECT_EN
    // arm waits for the next freshly loaded word; flip stays set until that word transfers
    logic arm, arm_n, flip;

    always_comb begin
        arm_n  = arm;
        flip_n = flip;
        if (bus.i_err_inject && !arm && !flip) arm_n = 1'b1;
        if (xfer) flip_n = 1'b0;
        if (load && arm_n) begin
            flip_n = 1'b1;
            arm_n  = 1'b0;
        end
    end

    always_ff @(posedge i_pac_gen_clk) begin
        if (i_rst) begin
            arm  <= 1'b0;
            flip <= 1'b0;
        end else begin
            arm  <= arm_n;
            flip <= flip_n;
        end
    end
`else
    logic unused_err_inject;
    assign unused_err_inject = bus.i_err_inject;
    assign flip_n = 1'b0;
`endif

    always_ff @(posedge i_pac_gen_clk) begin
        if (i_rst) begin
            state     <= P_IDLE;
            idx       <= 32'd0;
            gap_cnt   <= 32'd0;
            run_cnt   <= 32'd0;
            cnt_max   <= 32'd0;
            frame_num <= 32'd0;
            valid     <= 1'b0;
            data_q    <= 32'd0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            gap_cnt   <= gap_cnt_n;
            run_cnt   <= run_cnt_n;
            cnt_max   <= cnt_max_n;
            frame_num <= frame_num_n;
            valid     <= valid_n;
            data_q    <= {idx_n[31:1], idx_n[0] ^ flip_n};
            sof_q     <= valid_n && (idx_n == 32'd0);
            eof_q     <= valid_n && (idx_n == LAST_IDX);
            busy_q    <= (state_n == P_DATA) || (state_n == P_GAP);
            done_q    <= (state_n == P_DONE);
        end
    end

    assign bus.o_pac_gen_data       = data_q;
    assign bus.o_pac_gen_data_valid = valid;
    assign bus.o_pac_gen_sof        = sof_q;
    assign bus.o_pac_gen_eof        = eof_q;
    assign bus.o_frame_num          = frame_num;
    assign bus.o_busy               = busy_q;
    assign bus.o_done               = done_q;
endmodule

// File: tb/tb_pac_gen.sv
// Bench for pac_gen: directed runs with random backpressure, checked against a
// word-stream scoreboard (expected index, frame count, hold-while-stalled, gap length).
module tb_pac_gen;
    localparam int LEN = 40;
    localparam int GAP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pac_gen_if bus();

    pac_gen #(.FRAME_LEN_VAL(LEN), .GAP_LEN(GAP)) dut (
        .i_pac_gen_clk (clk),
        .i_rst         (rst),
        .bus           (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int          n_pass = 0;
    int          n_total = 0;
    int          exp_idx = 0;
    logic [31:0] exp_frames = 32'd0;
    int          n_xfer = 0;
    int          cyc = 0;
    int          first_xfer = -1;
    int          last_xfer = -1;
    bit          hold = 1'b0;
    logic [31:0] h_data;
    logic        h_sof, h_eof;
    bit          chk_gap = 1'b0;
    bit          after_eof = 1'b0;
    int          gap_run = 0;
    int          gap_checks = 0;
    bit          inj_armed = 1'b0;
    int          inj_idx = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // One clock: scoreboard at the negedge, then return 1 time unit after the posedge
    task automatic step();
        logic [31:0] want;
        @(negedge clk);
        cyc++;
        chk("frame_num", bus.o_frame_num, exp_frames);
        if (hold) begin
            chkb("hold_valid", bus.o_pac_gen_data_valid, 1'b1);
            chk("hold_data", bus.o_pac_gen_data, h_data);
            chkb("hold_sof", bus.o_pac_gen_sof, h_sof);
            chkb("hold_eof", bus.o_pac_gen_eof, h_eof);
        end
        if (rst) begin
            exp_idx = 0;
            exp_frames = 32'd0;
            hold = 1'b0;
            inj_armed = 1'b0;
            after_eof = 1'b0;
            gap_run = 0;
        end else begin
            if (bus.o_pac_gen_data_valid) begin
                if (chk_gap && after_eof) begin
                    chk("gap_len", gap_run, GAP);
                    gap_checks++;
                end
                after_eof = 1'b0;
                gap_run = 0;
            end else begin
                gap_run++;
            end
            if (bus.o_pac_gen_data_valid && bus.i_ready) begin
                want = 32'(exp_idx);
                if (inj_armed && exp_idx == inj_idx) begin
                    want[0] = ~want[0];
                    inj_armed = 1'b0;
                end
                chk("data", bus.o_pac_gen_data, want);
                chkb("sof", bus.o_pac_gen_sof, exp_idx == 0);
                chkb("eof", bus.o_pac_gen_eof, exp_idx == LEN - 1);
                n_xfer++;
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
                if (exp_idx == LEN - 1) begin
                    exp_idx = 0;
                    exp_frames = exp_frames + 32'd1;
                    after_eof = 1'b1;
                end else begin
                    exp_idx++;
                end
            end
            hold = bus.o_pac_gen_data_valid && !bus.i_ready;
            h_data = bus.o_pac_gen_data;
            h_sof = bus.o_pac_gen_sof;
            h_eof = bus.o_pac_gen_eof;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_done(input int budget);
        int k = 0;
        while (!bus.o_done && k < budget) begin
            step();
            k++;
        end
        chkb("reach_done", bus.o_done, 1'b1);
    endtask

    task automatic wait_word(input logic [31:0] w, input int budget);
        int k = 0;
        while (!(bus.o_pac_gen_data_valid && bus.o_pac_gen_data == w) && k < budget) begin
            step();
            k++;
        end
        chk("reach_word", bus.o_pac_gen_data, w);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, bus.o_pac_gen_data, 32'd0);
        chkb({tag, "_valid"}, bus.o_pac_gen_data_valid, 1'b0);
        chkb({tag, "_sof"}, bus.o_pac_gen_sof, 1'b0);
        chkb({tag, "_eof"}, bus.o_pac_gen_eof, 1'b0);
        chk({tag, "_frames"}, bus.o_frame_num, 32'd0);
        chkb({tag, "_busy"}, bus.o_busy, 1'b0);
        chkb({tag, "_done"}, bus.o_done, 1'b0);
    endtask

    initial begin
        int x0;
        int k;
        bus.i_enable = 1'b0;
        bus.i_frame_cnt_max = 32'd0;
        bus.i_ready = 1'b1;
        bus.i_err_inject = 1'b0;

        // reset state
        rst = 1'b1;
        step();
        step();
        chk_zero("rst");
        rst = 1'b0;

        // single frame, ready held high
        bus.i_frame_cnt_max = 32'd1;
        bus.i_enable = 1'b1;
        step();
        chkb("lat_valid", bus.o_pac_gen_data_valid, 1'b1);
        chk("lat_data", bus.o_pac_gen_data, 32'd0);
        chkb("lat_sof", bus.o_pac_gen_sof, 1'b1);
        chkb("t1_busy", bus.o_busy, 1'b1);
        run_done(200);
        chk("t1_xfers", n_xfer, LEN);
        chk("t1_span", last_xfer - first_xfer + 1, LEN);
        chk("t1_frames", bus.o_frame_num, 32'd1);
        chkb("t1_valid_off", bus.o_pac_gen_data_valid, 1'b0);
        chkb("t1_busy_off", bus.o_busy, 1'b0);
        bus.i_enable = 1'b0;
        step();
        chkb("t1_idle_done", bus.o_done, 1'b0);

        // three frames with idle gaps
        do_reset();
        chk_gap = 1'b1;
        after_eof = 1'b0;
        gap_checks = 0;
        bus.i_frame_cnt_max = 32'd3;
        bus.i_enable = 1'b1;
`ifndef PAC_GEN_ERR_INJECT_EN
        bus.i_err_inject = 1'b1;
`endif
        step();
        bus.i_err_inject = 1'b0;
        run_done(1000);
        chk_gap = 1'b0;
        chk("t2_gap_count", gap_checks, 2);
        chk("t2_frames", bus.o_frame_num, 32'd3);
        bus.i_enable = 1'b0;
        step();

        // random backpressure over two frames
        x0 = n_xfer;
        bus.i_frame_cnt_max = 32'd2;
        bus.i_enable = 1'b1;
        k = 0;
        while (!bus.o_done && k < 3000) begin
            bus.i_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        chkb("t3_done", bus.o_done, 1'b1);
        chk("t3_xfers", n_xfer - x0, 2 * LEN);
        chk("t3_frames", bus.o_frame_num, 32'd5);
        bus.i_ready = 1'b1;
        bus.i_enable = 1'b0;
        step();

        // continuous run, enable dropped mid-frame
        bus.i_frame_cnt_max = 32'd0;
        bus.i_enable = 1'b1;
        wait_word(32'd20, 200);
        bus.i_enable = 1'b0;
        k = 0;
        while (bus.o_busy && k < 200) begin
            step();
            k++;
        end
        chkb("t4_busy", bus.o_busy, 1'b0);
        chkb("t4_done", bus.o_done, 1'b0);
        chkb("t4_valid", bus.o_pac_gen_data_valid, 1'b0);
        chk("t4_frames", bus.o_frame_num, 32'd6);

        // reset mid-frame, then restart
        bus.i_enable = 1'b1;
        wait_word(32'd15, 200);
        rst = 1'b1;
        bus.i_frame_cnt_max = 32'd1;
        step();
        rst = 1'b0;
        chk_zero("midrst");
        step();
        chkb("restart_valid", bus.o_pac_gen_data_valid, 1'b1);
        chk("restart_data", bus.o_pac_gen_data, 32'd0);
        chkb("restart_sof", bus.o_pac_gen_sof, 1'b1);
        run_done(200);
        chk("t5_frames", bus.o_frame_num, 32'd1);
        bus.i_enable = 1'b0;
        step();

`ifdef PAC_GEN_ERR_INJECT_EN
        // corrupt word 5 of a single frame
        do_reset();
        bus.i_frame_cnt_max = 32'd1;
        bus.i_enable = 1'b1;
        wait_word(32'd4, 200);
        bus.i_err_inject = 1'b1;
        inj_armed = 1'b1;
        inj_idx = 5;
        step();
        bus.i_err_inject = 1'b0;
        run_done(200);
        chk("inj_frames", bus.o_frame_num, 32'd1);
        bus.i_enable = 1'b0;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
